// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants, default widths, issue-stage states.
package alu_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_REG_ADDR_W = 5;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLT = 4'b0101;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } issue_state_e;

endpackage

// File: rtl/alu_fwd_mux.sv
// Operand select for one source register: x0, EX result, MEM result, regfile.
// With ALU_ISSUE_FWD_EN undefined the mux collapses to the regfile data.
module alu_fwd_mux
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_rf_data,
    input  logic                  i_ex_we,
    input  logic [REG_ADDR_W-1:0] i_ex_rd,
    input  logic                  i_ex_is_load,
    input  logic [DATA_WIDTH-1:0] i_ex_data,
    input  logic                  i_mem_we,
    input  logic [REG_ADDR_W-1:0] i_mem_rd,
    input  logic [DATA_WIDTH-1:0] i_mem_data,
    output logic [DATA_WIDTH-1:0] o_data
);

`ifdef ALU_ISSUE_FWD_EN
    // Priority select; a load in EX has no data yet, so it never forwards here.
    always_comb begin
        o_data = i_rf_data;
        if (i_addr == '0) begin
            o_data = '0;
        end else if (i_ex_we && !i_ex_is_load && (i_ex_rd == i_addr)) begin
            o_data = i_ex_data;
        end else if (i_mem_we && (i_mem_rd == i_addr)) begin
            o_data = i_mem_data;
        end
    end
`else
    logic unused_fwd;

    assign o_data     = i_rf_data;
    assign unused_fwd = ^{i_addr, i_ex_we, i_ex_rd, i_ex_is_load, i_ex_data,
                          i_mem_we, i_mem_rd, i_mem_data};
`endif

endmodule

// File: rtl/alu_issue_stage.sv
// Execute-issue register in front of the ALU: valid/ready intake, operand
// resolution, load-use bubble insertion and a saturating stall counter.
// Optional macro ALU_ISSUE_FWD_EN enables EX/MEM forwarding; without it every
// pending EX/MEM write to a used source stalls instead.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int REG_ADDR_W  = DEF_REG_ADDR_W,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [REG_ADDR_W-1:0]  i_rs1_addr,
    input  logic [REG_ADDR_W-1:0]  i_rs2_addr,
    input  logic [DATA_WIDTH-1:0]  i_rs1_data,
    input  logic [DATA_WIDTH-1:0]  i_rs2_data,
    input  logic [DATA_WIDTH-1:0]  i_imm,
    input  logic                   i_use_imm,
    input  logic [3:0]             i_aluctr,
    input  logic [REG_ADDR_W-1:0]  i_rd_addr,
    input  logic                   i_rd_we,
    input  logic                   i_ex_we,
    input  logic [REG_ADDR_W-1:0]  i_ex_rd,
    input  logic [DATA_WIDTH-1:0]  i_ex_data,
    input  logic                   i_ex_is_load,
    input  logic                   i_mem_we,
    input  logic [REG_ADDR_W-1:0]  i_mem_rd,
    input  logic [DATA_WIDTH-1:0]  i_mem_data,
    input  logic                   i_flush,
    input  logic                   i_ready,
    output logic                   o_valid,
    output logic [DATA_WIDTH-1:0]  o_a,
    output logic [DATA_WIDTH-1:0]  o_b,
    output logic [3:0]             o_aluctr,
    output logic [REG_ADDR_W-1:0]  o_rd_addr,
    output logic                   o_rd_we,
    output logic [STALL_CNT_W-1:0] o_stall_cnt
);

    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    endfunction

    issue_state_e            state_p1, state_nxt;
    logic [DATA_WIDTH-1:0]   a_p0, rs2_p0, b_p0;
    logic [DATA_WIDTH-1:0]   a_p1, b_p1;
    logic [3:0]              op_p1;
    logic [REG_ADDR_W-1:0]   rd_p1;
    logic                    we_p1;
    logic                    vld_p1;
    logic [STALL_CNT_W-1:0]  stall_cnt_p1;
    logic                    ex_hit1, ex_hit2;
    logic                    hazard;
    logic                    accept;

    // ---- stage 0: hazard detection and operand resolution ----
    assign ex_hit1 = i_ex_we && (i_ex_rd != '0) && (i_ex_rd == i_rs1_addr);
    assign ex_hit2 = i_ex_we && (i_ex_rd != '0) && !i_use_imm && (i_ex_rd == i_rs2_addr);

`ifdef ALU_ISSUE_FWD_EN
    assign hazard = i_valid && i_ex_is_load && (ex_hit1 || ex_hit2);
`else
    logic mem_hit1, mem_hit2;

    assign mem_hit1 = i_mem_we && (i_mem_rd != '0) && (i_mem_rd == i_rs1_addr);
    assign mem_hit2 = i_mem_we && (i_mem_rd != '0) && !i_use_imm && (i_mem_rd == i_rs2_addr);
    assign hazard   = i_valid && (ex_hit1 || ex_hit2 || mem_hit1 || mem_hit2);
`endif

    assign vld_p1  = (state_p1 == ST_FULL);
    assign o_ready = !i_flush && !hazard && (!vld_p1 || i_ready);
    assign accept  = i_valid && o_ready;

    alu_fwd_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_rs1 (
        .i_addr       (i_rs1_addr),
        .i_rf_data    (i_rs1_data),
        .i_ex_we      (i_ex_we),
        .i_ex_rd      (i_ex_rd),
        .i_ex_is_load (i_ex_is_load),
        .i_ex_data    (i_ex_data),
        .i_mem_we     (i_mem_we),
        .i_mem_rd     (i_mem_rd),
        .i_mem_data   (i_mem_data),
        .o_data       (a_p0)
    );

    alu_fwd_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_rs2 (
        .i_addr       (i_rs2_addr),
        .i_rf_data    (i_rs2_data),
        .i_ex_we      (i_ex_we),
        .i_ex_rd      (i_ex_rd),
        .i_ex_is_load (i_ex_is_load),
        .i_ex_data    (i_ex_data),
        .i_mem_we     (i_mem_we),
        .i_mem_rd     (i_mem_rd),
        .i_mem_data   (i_mem_data),
        .o_data       (rs2_p0)
    );

    assign b_p0 = i_use_imm ? i_imm : rs2_p0;

    // ---- stage 1: issue register facing the ALU ----
    // State register: EMPTY/FULL occupancy of the issue slot.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_p1 <= ST_EMPTY;
        end else begin
            state_p1 <= state_nxt;
        end
    end

    // Next state: flush empties, accept fills, a drain with no refill empties.
    always_comb begin
        state_nxt = state_p1;
        if (i_flush) begin
            state_nxt = ST_EMPTY;
        end else if (accept) begin
            state_nxt = ST_FULL;
        end else if (vld_p1 && i_ready) begin
            state_nxt = ST_EMPTY;
        end
    end

    // Payload: loads on accept, otherwise holds so outputs stay stable under backpressure.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_p1  <= '0;
            b_p1  <= '0;
            op_p1 <= ALU_ADD;
            rd_p1 <= '0;
            we_p1 <= 1'b0;
        end else if (i_flush) begin
            we_p1 <= 1'b0;
        end else if (accept) begin
            a_p1  <= a_p0;
            b_p1  <= b_p0;
            op_p1 <= i_aluctr;
            rd_p1 <= i_rd_addr;
            we_p1 <= i_rd_we;
        end
    end

    // Stall counter: one count per bubble cycle, pinned at all-ones.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_cnt_p1 <= '0;
        end else if (hazard) begin
            stall_cnt_p1 <= sat_inc(stall_cnt_p1);
        end
    end

    assign o_valid     = vld_p1;
    assign o_a         = a_p1;
    assign o_b         = b_p1;
    assign o_aluctr    = op_p1;
    assign o_rd_addr   = rd_p1;
    assign o_rd_we     = we_p1;
    assign o_stall_cnt = stall_cnt_p1;

endmodule
